// File: rtl/zx81_tape_player.sv
// ZX81 tape playback: turns a .p/.o image in the tape buffer into the ROM's pulse-train waveform.
// Define TAPE_NAME_EN to play a synthetic end-of-name byte (8'hA6) before the image.
module zx81_tape_player #(
  parameter int PULSE_CYCLES  = 7800,
  parameter int GAP_CYCLES    = 67600,
  parameter int LEADER_CYCLES = 26000000,
  parameter int ADDR_W        = 14
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              tape_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, LEADER, FETCH, WAIT, PULSE_HI, PULSE_LO, GAP, END} state_t;

  localparam logic [26:0] PULSE_LD  = 27'(PULSE_CYCLES - 1);
  localparam logic [26:0] GAP_LD    = 27'(GAP_CYCLES - 1);
  localparam logic [26:0] LEADER_LD = 27'(LEADER_CYCLES - 1);

  state_t            state;
  logic [26:0]       dur;
  logic [3:0]        pcnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic [ADDR_W-1:0] len_q;
  logic              more_bytes;
`ifdef TAPE_NAME_EN
  logic              name_pend;
`endif

  // pcnt holds pulses remaining after the current one
  function automatic logic [3:0] pulses_m1(input logic b);
    return b ? 4'd8 : 4'd3;
  endfunction

  assign more_bytes = ((ADDR_W+1)'(mem_addr) + (ADDR_W+1)'(1)) < (ADDR_W+1)'(len_q);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      dur      <= '0;
      pcnt     <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      len_q    <= '0;
      mem_addr <= '0;
      tape_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef TAPE_NAME_EN
      name_pend <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (stop && busy) begin
        state    <= IDLE;
        tape_out <= 1'b0;
        busy     <= 1'b0;
        dur      <= '0;
        pcnt     <= '0;
      end else if (start && len != '0) begin
        state    <= LEADER;
        len_q    <= len;
        mem_addr <= '0;
        busy     <= 1'b1;
        tape_out <= 1'b0;
        dur      <= LEADER_LD;
        pcnt     <= '0;
`ifdef TAPE_NAME_EN
        name_pend <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: ;
          LEADER:
            if (dur == '0) begin
`ifdef TAPE_NAME_EN
              shreg    <= 8'hA6;
              bit_idx  <= 3'd7;
              pcnt     <= pulses_m1(1'b1);
              dur      <= PULSE_LD;
              tape_out <= 1'b1;
              state    <= PULSE_HI;
`else
              state <= FETCH;
`endif
            end else dur <= dur - 27'd1;
          FETCH: begin
            dur   <= 27'd1;
            state <= WAIT;
          end
          // two wait cycles cover the buffer's read latency
          WAIT:
            if (dur == '0) begin
              shreg    <= mem_data;
              bit_idx  <= 3'd7;
              pcnt     <= pulses_m1(mem_data[7]);
              dur      <= PULSE_LD;
              tape_out <= 1'b1;
              state    <= PULSE_HI;
            end else dur <= dur - 27'd1;
          PULSE_HI:
            if (dur == '0) begin
              dur      <= PULSE_LD;
              tape_out <= 1'b0;
              state    <= PULSE_LO;
            end else dur <= dur - 27'd1;
          PULSE_LO:
            if (dur == '0) begin
              if (pcnt == '0) begin
                dur   <= GAP_LD;
                state <= GAP;
              end else begin
                pcnt     <= pcnt - 4'd1;
                dur      <= PULSE_LD;
                tape_out <= 1'b1;
                state    <= PULSE_HI;
              end
            end else dur <= dur - 27'd1;
          GAP:
            if (dur == '0) begin
              if (bit_idx != '0) begin
                bit_idx  <= bit_idx - 3'd1;
                shreg    <= {shreg[6:0], 1'b0};
                pcnt     <= pulses_m1(shreg[6]);
                dur      <= PULSE_LD;
                tape_out <= 1'b1;
                state    <= PULSE_HI;
              end
`ifdef TAPE_NAME_EN
              else if (name_pend) begin
                name_pend <= 1'b0;
                state     <= FETCH;
              end
`endif
              else if (more_bytes) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                state    <= FETCH;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= END;
              end
            end else dur <= dur - 27'd1;
          END: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zx81_tape_player.sv
// Randomized bench: decodes the tape waveform back into bytes and checks it against the image.
module tb_zx81_tape_player;
  localparam int P = 4, G = 20, L = 10, AW = 14;

  logic          clk_sys = 1'b0;
  logic          reset, start, stop;
  logic [AW-1:0] len, mem_addr;
  logic [7:0]    mem_data;
  logic          tape_out, busy, done;

  zx81_tape_player #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .LEADER_CYCLES(L), .ADDR_W(AW)) dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .stop(stop), .len(len),
    .mem_addr(mem_addr), .mem_data(mem_data), .tape_out(tape_out), .busy(busy), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  // tape buffer with two-edge read latency
  logic [7:0] img [16];
  logic [7:0] d1;
  always @(posedge clk_sys) begin
    d1       <= img[mem_addr[3:0]];
    mem_data <= d1;
  end

  int total = 0, bad = 0;
  int rises = 0, bad_hi = 0, bad_lo = 0, dones = 0, addr_over = 0;
  int hi_run = 0, lo_run = 1000, grp = 0, cur_len = 0;
  bit prev = 1'b0;
  int grps[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // waveform monitor: counts edges, checks phase widths, groups pulses into bits
  initial forever begin
    @(negedge clk_sys);
    if (done) dones++;
    if (busy && cur_len > 0 && int'(mem_addr) >= cur_len) addr_over++;
    if (tape_out && !prev) begin
      rises++;
      if (grp > 0 && lo_run > P) begin grps.push_back(grp); grp = 0; end
      else if (grp > 0 && lo_run != P) bad_lo++;
      grp++;
      hi_run = 1;
    end else if (tape_out) hi_run++;
    else if (prev) begin
      if (hi_run != P) bad_hi++;
      lo_run = 1;
    end else lo_run++;
    if (done && grp > 0) begin grps.push_back(grp); grp = 0; end
    if (!busy && !done) grp = 0;
    prev = tape_out;
  end

  task automatic pulse_start(input int n);
    len   = AW'(n);
    start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
  endtask

  // one full playback of img[0..n-1], expectations from the encoding rules
  task automatic play(input int n, input string tag);
    logic [7:0] bytes[$];
    int k, r0, bh0, bl0, d0, exp_e, exp_k, nb, base, nbad, pc, e;
    logic [7:0] v;
    exp_k = L + 1; exp_e = 0;
`ifdef TAPE_NAME_EN
    bytes.push_back(8'hA6);
`endif
    for (int i = 0; i < n; i++) begin bytes.push_back(img[i]); exp_k += 3; end
    foreach (bytes[i]) begin
      pc = $countones(bytes[i]);
      e = 4 * (8 - pc) + 9 * pc;
      exp_e += e;
      exp_k += 8 * G + 2 * P * e;
    end
    d0 = dones;
    pulse_start(n);
    cur_len = n;
    chk({tag, ":addr0"}, mem_addr, 0);
    k = 0; r0 = 0; bh0 = 0; bl0 = 0;
    while (1) begin
      @(negedge clk_sys); #1;
      k++;
      if (k == 1) begin r0 = rises; bh0 = bad_hi; bl0 = bad_lo; end
      if (dones > d0 || k > exp_k + 50) break;
    end
    chk({tag, ":cycles"}, k, exp_k);
    chk({tag, ":edges"}, rises - r0, exp_e);
    chk({tag, ":hi_w"}, bad_hi - bh0, 0);
    chk({tag, ":lo_w"}, bad_lo - bl0, 0);
    nb = bytes.size() * 8;
    if (grps.size() >= nb) begin
      base = grps.size() - nb; nbad = 0;
      foreach (bytes[j]) begin
        v = 8'h00;
        for (int b = 0; b < 8; b++) begin
          if (grps[base + j*8 + b] != 4 && grps[base + j*8 + b] != 9) nbad++;
          v = {v[6:0], grps[base + j*8 + b] == 9};
        end
        chk({tag, ":byte"}, v, bytes[j]);
      end
      chk({tag, ":bitgrp"}, nbad, 0);
    end else chk({tag, ":ngrp"}, grps.size(), nb);
    repeat (4) begin @(negedge clk_sys); #1; end
    chk({tag, ":dones"}, dones - d0, 1);
    chk({tag, ":busy"}, busy, 0);
    chk({tag, ":last_addr"}, mem_addr, n - 1);
    chk({tag, ":addr_over"}, addr_over, 0);
  endtask

  initial begin
    int t, r, d, n;
    reset = 1'b1; start = 1'b0; stop = 1'b0; len = '0;
    foreach (img[i]) img[i] = 8'h00;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys); #1;
    chk("rst:tape", tape_out, 0);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:addr", mem_addr, 0);
    reset = 1'b0;
    @(negedge clk_sys); #1;

    // zero-length start is ignored
    r = rises; d = dones;
    pulse_start(0);
    t = 0;
    repeat (30) begin @(negedge clk_sys); #1; if (busy || tape_out) t++; end
    chk("len0:active", t, 0);
    chk("len0:edges", rises - r, 0);
    chk("len0:dones", dones - d, 0);
    chk("len0:addr", mem_addr, 0);

    img[0] = 8'h80;
    play(1, "one80");

    img[0] = 8'h00; img[1] = 8'hFF; img[2] = 8'h0F;
    play(3, "three");

    // stop during a high phase of byte 1
    img[0] = 8'($urandom); img[1] = 8'($urandom);
    pulse_start(2);
    cur_len = 2;
    t = 0;
    while (!(mem_addr == 1 && tape_out) && t < 5000) begin @(negedge clk_sys); #1; t++; end
    chk("stop:reach", t < 5000, 1);
    stop = 1'b1;
    @(posedge clk_sys); #1;
    stop = 1'b0;
    d = dones;
    @(negedge clk_sys); #1;
    chk("stop:tape", tape_out, 0);
    chk("stop:busy", busy, 0);
    repeat (10) begin @(negedge clk_sys); #1; end
    chk("stop:nodone", dones - d, 0);
    play(2, "replay");

    // restart while busy
    img[0] = 8'($urandom); img[1] = 8'($urandom); img[2] = 8'($urandom);
    pulse_start(3);
    cur_len = 3;
    t = 0;
    while (mem_addr != 1 && t < 5000) begin @(negedge clk_sys); #1; t++; end
    chk("restart:busy", busy, 1);
    play(2, "restart");

    // reset in the middle of a gap
    img[0] = 8'($urandom);
    r = rises;
    pulse_start(1);
    cur_len = 1;
    t = 0;
    while (!(rises > r && !tape_out && lo_run == P + 3) && t < 5000) begin @(negedge clk_sys); #1; t++; end
    chk("rstgap:reach", t < 5000, 1);
    reset = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    chk("rstgap:tape", tape_out, 0);
    chk("rstgap:busy", busy, 0);
    chk("rstgap:done", done, 0);
    chk("rstgap:addr", mem_addr, 0);
    @(negedge clk_sys); #1;

    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) img[i] = 8'($urandom);
      play(n, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
